pi_loop_sequencer: RTL and testbench

- Sequences one PI-controller iteration per sample period: ADC sample request, error computation, PI datapath start/done handshake, DAC output handoff.
- Sits between the AXI4-Lite register bank (cfg_*/status, software-visible) and the PI arithmetic datapath.
- Adds period timing, overrun detection, per-phase timeout fault and saturated error generation.

---
 rtl/pi_seq_pkg.sv | 68 ++++++
 rtl/pi_seq_period_timer.sv | 51 +++++
 rtl/pi_loop_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_pi_loop_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_seq_pkg.sv
// Shared definitions for the PI loop sequencer: state encoding, default
// widths/limits, the saturating error subtractor and the output clamp helper.
package pi_seq_pkg;

    // Default sizing; the datapath helpers below are built at PI_DATA_W.
    localparam int PI_DATA_W   = 16;
    localparam int PI_PERIOD_W = 16;
    localparam int PI_TIMEOUT  = 64;
    localparam int PI_ITER_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_SAMPLE    = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_OUTPUT    = 3'd4,
        ST_FAULT     = 3'd5
    } pi_seq_state_t;

    // Result of the optional output clamp: the value to hand to the DAC and
    // whether it differs from the raw PI result.
    typedef struct packed {
        logic                        hit;
        logic signed [PI_DATA_W-1:0] value;
    } clamp_res_t;

    // a - b computed one bit wider, then saturated back into PI_DATA_W bits.
    // Overflow is detected by the top two bits of the wide result disagreeing.
    function automatic logic signed [PI_DATA_W-1:0] sat_sub(
        input logic signed [PI_DATA_W-1:0] a,
        input logic signed [PI_DATA_W-1:0] b
    );
        logic signed [PI_DATA_W:0] diff;
        diff = {a[PI_DATA_W-1], a} - {b[PI_DATA_W-1], b};
        if (diff[PI_DATA_W] != diff[PI_DATA_W-1]) begin
            if (diff[PI_DATA_W]) begin
                sat_sub = {1'b1, {(PI_DATA_W-1){1'b0}}};
            end else begin
                sat_sub = {1'b0, {(PI_DATA_W-1){1'b1}}};
            end
        end else begin
            sat_sub = diff[PI_DATA_W-1:0];
        end
    endfunction

    // Clamp x into [lo, hi]. An inverted window (lo > hi) always yields lo.
    function automatic clamp_res_t clamp_out(
        input logic signed [PI_DATA_W-1:0] x,
        input logic signed [PI_DATA_W-1:0] lo,
        input logic signed [PI_DATA_W-1:0] hi
    );
        clamp_res_t r;
        r.hit   = 1'b0;
        r.value = x;
        if (lo > hi) begin
            r.value = lo;
            r.hit   = (x != lo);
        end else if (x > hi) begin
            r.value = hi;
            r.hit   = 1'b1;
        end else if (x < lo) begin
            r.value = lo;
            r.hit   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pi_seq_period_timer.sv
// Sample-period timer: counts 0..limit while enabled and pulses tick on the
// terminal count. The limit is re-read from 'period' only at a wrap or clear,
// so a period change never truncates or stretches the period in flight.
module pi_seq_period_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] limit_q, limit_d;

    // Terminal count detect; a clear cycle never ticks.
    always_comb begin
        tick = en && !clr && (cnt_q == limit_q);
    end

    // Next count: clear restarts at 0, otherwise count up and wrap at limit.
    always_comb begin
        cnt_d   = cnt_q;
        limit_d = limit_q;
        if (clr) begin
            cnt_d   = '0;
            limit_d = period;
        end else if (en) begin
            if (cnt_q == limit_q) begin
                cnt_d   = '0;
                limit_d = period;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and latched limit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            limit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/pi_loop_sequencer.sv
// PI loop sequencer: one controller iteration per sample period
// (ADC request -> saturated error -> PI start/done -> DAC valid/ready),
// with overrun detection and per-state timeout fault.
// Optional output clamp enabled by defining PI_SEQ_OUT_CLAMP_EN.
//
// Handshakes: adc_req/adc_valid, and dac_valid/dac_ready, are valid/ready
// pairs: the request/valid side holds its signal (and data) high until the
// cycle the other side asserts its strobe, which is the transfer cycle.
// pi_start/pi_done are single-cycle pulses; pi_error is stable in between.
module pi_loop_sequencer
    import pi_seq_pkg::*;
#(
    parameter int DATA_W   = PI_DATA_W,   // must equal PI_DATA_W (helper width)
    parameter int PERIOD_W = PI_PERIOD_W,
    parameter int TIMEOUT  = PI_TIMEOUT
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cfg_enable,
    input  logic [PERIOD_W-1:0]      cfg_period,
    input  logic signed [DATA_W-1:0] cfg_setpoint,
    input  logic                     status_clr,
    output logic                     adc_req,
    input  logic                     adc_valid,
    input  logic signed [DATA_W-1:0] adc_data,
    output logic                     pi_start,
    output logic signed [DATA_W-1:0] pi_error,
    input  logic                     pi_done,
    input  logic signed [DATA_W-1:0] pi_out,
    output logic                     dac_valid,
    output logic signed [DATA_W-1:0] dac_data,
    input  logic                     dac_ready,
    output logic                     busy,
    output logic                     overrun,
    output logic                     fault,
`ifdef PI_SEQ_OUT_CLAMP_EN
    input  logic signed [DATA_W-1:0] cfg_out_min,
    input  logic signed [DATA_W-1:0] cfg_out_max,
    output logic                     clamp_hit,
`endif
    output logic [PI_ITER_W-1:0]     iter_cnt
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    pi_seq_state_t state_q, state_d;
    logic [TO_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                     adc_req_q, adc_req_d;
    logic                     pi_start_q, pi_start_d;
    logic signed [DATA_W-1:0] pi_error_q, pi_error_d;
    logic                     dac_valid_q, dac_valid_d;
    logic signed [DATA_W-1:0] dac_data_q, dac_data_d;
    logic                     overrun_q, overrun_d;
    logic [PI_ITER_W-1:0]     iter_cnt_q, iter_cnt_d;
    logic                     timer_clr;
    logic                     tick;
    logic                     timed_out;
    logic                     in_iter;
`ifdef PI_SEQ_OUT_CLAMP_EN
    logic                     clamp_hit_q, clamp_hit_d;
    clamp_res_t               clamp_r;
`endif

    pi_seq_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .en     (cfg_enable),
        .clr    (timer_clr),
        .period (cfg_period),
        .tick   (tick)
    );

    // Wait-state qualifiers: last allowed cycle in a state, and iteration phase.
    always_comb begin
        timed_out = (wait_cnt_q == TO_W'(TIMEOUT - 1));
        in_iter   = (state_q == ST_SAMPLE) || (state_q == ST_COMPUTE) ||
                    (state_q == ST_OUTPUT);
    end

`ifdef PI_SEQ_OUT_CLAMP_EN
    // Clamp the incoming PI result against the software window.
    always_comb begin
        clamp_r = clamp_out(pi_out, cfg_out_min, cfg_out_max);
    end
`endif

    // Next-state and registered-output logic of the iteration FSM.
    always_comb begin
        state_d     = state_q;
        adc_req_d   = adc_req_q;
        pi_start_d  = 1'b0;
        pi_error_d  = pi_error_q;
        dac_valid_d = dac_valid_q;
        dac_data_d  = dac_data_q;
        iter_cnt_d  = iter_cnt_q;
        timer_clr   = 1'b0;
`ifdef PI_SEQ_OUT_CLAMP_EN
        clamp_hit_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d   = ST_WAIT_TICK;
                    timer_clr = 1'b1;
                end
            end
            ST_WAIT_TICK: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d   = ST_SAMPLE;
                    adc_req_d = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (adc_valid) begin
                    pi_error_d = sat_sub(cfg_setpoint, adc_data);
                    adc_req_d  = 1'b0;
                    pi_start_d = 1'b1;
                    state_d    = ST_COMPUTE;
                end else if (timed_out) begin
                    adc_req_d = 1'b0;
                    state_d   = ST_FAULT;
                end
            end
            ST_COMPUTE: begin
                if (pi_done) begin
`ifdef PI_SEQ_OUT_CLAMP_EN
                    dac_data_d  = clamp_r.value;
                    clamp_hit_d = clamp_r.hit;
`else
                    dac_data_d  = pi_out;
`endif
                    dac_valid_d = 1'b1;
                    state_d     = ST_OUTPUT;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end
            end
            ST_OUTPUT: begin
                if (dac_ready) begin
                    dac_valid_d = 1'b0;
                    iter_cnt_d  = iter_cnt_q + 1'b1;
                    state_d     = cfg_enable ? ST_WAIT_TICK : ST_IDLE;
                end else if (timed_out) begin
                    dac_valid_d = 1'b0;
                    state_d     = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                adc_req_d   = 1'b0;
                dac_valid_d = 1'b0;
            end
        endcase
    end

    // Per-state wait counter (restarts on every state change) and sticky
    // overrun flag, where a new overrun outranks a simultaneous clear.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_d == state_q) && in_iter) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        overrun_d = overrun_q;
        if (tick && in_iter) begin
            overrun_d = 1'b1;
        end else if (status_clr) begin
            overrun_d = 1'b0;
        end
    end

    // State and output registers; reset drops every output asynchronously.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            adc_req_q   <= 1'b0;
            pi_start_q  <= 1'b0;
            pi_error_q  <= '0;
            dac_valid_q <= 1'b0;
            dac_data_q  <= '0;
            overrun_q   <= 1'b0;
            iter_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            adc_req_q   <= adc_req_d;
            pi_start_q  <= pi_start_d;
            pi_error_q  <= pi_error_d;
            dac_valid_q <= dac_valid_d;
            dac_data_q  <= dac_data_d;
            overrun_q   <= overrun_d;
            iter_cnt_q  <= iter_cnt_d;
        end
    end

`ifdef PI_SEQ_OUT_CLAMP_EN
    // Clamp indication pulse, aligned with the first dac_valid cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            clamp_hit_q <= 1'b0;
        end else begin
            clamp_hit_q <= clamp_hit_d;
        end
    end
    assign clamp_hit = clamp_hit_q;
`endif

    assign adc_req   = adc_req_q;
    assign pi_start  = pi_start_q;
    assign pi_error  = pi_error_q;
    assign dac_valid = dac_valid_q;
    assign dac_data  = dac_data_q;
    assign overrun   = overrun_q;
    assign iter_cnt  = iter_cnt_q;
    assign fault     = (state_q == ST_FAULT);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_WAIT_TICK);

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Bench for pi_loop_sequencer: table vectors, random iterations against a
// behavioural model, and hand-written timing/fault/reset sequences.
// Builds with or without PI_SEQ_OUT_CLAMP_EN.
module tb_pi_loop_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_period = 16'd0;
    logic [15:0] cfg_setpoint = 16'd0;
    logic        status_clr = 1'b0;
    logic        adc_req;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = 16'd0;
    logic        pi_start;
    logic [15:0] pi_error;
    logic        pi_done = 1'b0;
    logic [15:0] pi_out = 16'd0;
    logic        dac_valid;
    logic [15:0] dac_data;
    logic        dac_ready = 1'b0;
    logic        busy;
    logic        overrun;
    logic        fault;
    logic [15:0] iter_cnt;
`ifdef PI_SEQ_OUT_CLAMP_EN
    logic [15:0] cfg_out_min = 16'h8000;
    logic [15:0] cfg_out_max = 16'h7FFF;
    logic        clamp_hit;
    logic        last_hit;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          exp_iter = 0;
    int          last_req_cyc = 0;
    logic [15:0] last_err;
    logic [15:0] last_dac;

    typedef struct {
        logic [15:0] sp;
        logic [15:0] adc;
        logic [15:0] po;
        logic [15:0] exp_err;
        logic [15:0] exp_dac;
    } vec_t;
    vec_t tbl[7];

    pi_loop_sequencer dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_enable   (cfg_enable),
        .cfg_period   (cfg_period),
        .cfg_setpoint (cfg_setpoint),
        .status_clr   (status_clr),
        .adc_req      (adc_req),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .pi_start     (pi_start),
        .pi_error     (pi_error),
        .pi_done      (pi_done),
        .pi_out       (pi_out),
        .dac_valid    (dac_valid),
        .dac_data     (dac_data),
        .dac_ready    (dac_ready),
        .busy         (busy),
        .overrun      (overrun),
        .fault        (fault),
`ifdef PI_SEQ_OUT_CLAMP_EN
        .cfg_out_min  (cfg_out_min),
        .cfg_out_max  (cfg_out_max),
        .clamp_hit    (clamp_hit),
`endif
        .iter_cnt     (iter_cnt)
    );

    // Clock and cycle counter.
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact signed difference, then clipped to the 16-bit range.
    function automatic logic [15:0] model_err(input logic [15:0] sp, input logic [15:0] adc);
        int e;
        e = int'($signed(sp)) - int'($signed(adc));
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
        return 16'(e);
    endfunction

    // Reference: value handed to the DAC for a given PI result.
    function automatic logic [15:0] model_dac(input logic [15:0] po);
`ifdef PI_SEQ_OUT_CLAMP_EN
        int p, lo, hi;
        p  = $signed(po);
        lo = $signed(cfg_out_min);
        hi = $signed(cfg_out_max);
        if (lo > hi) return cfg_out_min;
        if (p > hi) return cfg_out_max;
        if (p < lo) return cfg_out_min;
`endif
        return po;
    endfunction

    // One full iteration, driven from a negedge and returning on a negedge.
    task automatic do_iter(input logic [15:0] sp, input logic [15:0] adc, input logic [15:0] po,
                           input int adc_dly, input int pi_dly, input int rdy_dly, input bit drop_en);
        int n;
        cfg_setpoint = sp;
        n = 0;
        while (adc_req !== 1'b1 && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        if (adc_req !== 1'b1) begin
            check("adc_req_wait_timeout", adc_req, 1);
            return;
        end
        last_req_cyc = cyc;
        for (int i = 0; i < adc_dly; i++) begin
            @(negedge ACLK);
            check("adc_req_held", adc_req, 1);
        end
        adc_valid = 1'b1;
        adc_data  = adc;
        @(negedge ACLK);
        adc_valid = 1'b0;
        adc_data  = ~adc;
        check("pi_start_latency", pi_start, 1);
        check("adc_req_drop", adc_req, 0);
        check("pi_error", pi_error, model_err(sp, adc));
        check("busy_in_iter", busy, 1);
        last_err = pi_error;
        if (drop_en) cfg_enable = 1'b0;
        for (int i = 0; i < pi_dly; i++) begin
            @(negedge ACLK);
            check("pi_start_one_cycle", pi_start, 0);
            check("pi_error_stable", pi_error, model_err(sp, adc));
        end
        pi_done = 1'b1;
        pi_out  = po;
        @(negedge ACLK);
        pi_done = 1'b0;
        pi_out  = ~po;
        check("dac_valid_latency", dac_valid, 1);
        check("dac_data", dac_data, model_dac(po));
        last_dac = dac_data;
`ifdef PI_SEQ_OUT_CLAMP_EN
        check("clamp_hit", clamp_hit, model_dac(po) != po);
        last_hit = clamp_hit;
`endif
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge ACLK);
            check("dac_valid_held", dac_valid, 1);
            check("dac_data_held", dac_data, model_dac(po));
        end
        dac_ready = 1'b1;
        @(negedge ACLK);
        dac_ready = 1'b0;
        check("dac_valid_drop", dac_valid, 0);
        exp_iter++;
        check("iter_cnt", iter_cnt, 32'(exp_iter & 16'hFFFF));
    endtask

    initial begin
        int r0, n, seen;
        logic [15:0] sp, adc, po;

        tbl[0] = '{16'h0064, 16'h0028, 16'h0123, 16'h003C, 16'h0123};
        tbl[1] = '{16'h7FFF, 16'h8000, 16'h1111, 16'h7FFF, 16'h1111};
        tbl[2] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 16'hFFFF};
        tbl[3] = '{16'h0000, 16'h0005, 16'h8000, 16'hFFFB, 16'h8000};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[5] = '{16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000, 16'h0001};
        tbl[6] = '{16'h1000, 16'h1000, 16'h4321, 16'h0000, 16'h4321};

        // Reset values.
        #2 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_adc_req", adc_req, 0);
        check("rst_pi_start", pi_start, 0);
        check("rst_pi_error", pi_error, 0);
        check("rst_dac_valid", dac_valid, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fault", fault, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Basic iterations, period 9 -> one iteration every 10 cycles.
        cfg_period = 16'd9;
        cfg_enable = 1'b1;
        do_iter(16'd100, 16'd40, 16'h0123, 0, 0, 0, 0);
        check("basic_err", last_err, 16'd60);
        check("basic_dac", last_dac, 16'h0123);
        r0 = last_req_cyc;
        do_iter(16'd100, 16'd40, 16'h0123, 0, 0, 0, 0);
        check("basic_spacing_1", last_req_cyc - r0, 10);
        r0 = last_req_cyc;
        do_iter(16'd100, 16'd40, 16'h0123, 0, 0, 0, 0);
        check("basic_spacing_2", last_req_cyc - r0, 10);
        check("basic_no_overrun", overrun, 0);

        // Table vectors including saturation boundaries.
        cfg_period = 16'd24;
        for (int i = 0; i < 7; i++) begin
            do_iter(tbl[i].sp, tbl[i].adc, tbl[i].po, 1, 2, 1, 0);
            check("tbl_err", last_err, tbl[i].exp_err);
            check("tbl_dac", last_dac, tbl[i].exp_dac);
        end

        // Random iterations against the model.
        cfg_period = 16'd49;
        for (int i = 0; i < 20; i++) begin
            sp  = 16'($urandom);
            adc = 16'($urandom);
            po  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) sp = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 3) == 0) adc = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            do_iter(sp, adc, po, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 0);
        end
        check("rand_no_overrun", overrun, 0);

        // Backpressure for 5 cycles, and disable during COMPUTE.
        do_iter(16'h0200, 16'h0100, 16'h0ABC, 0, 3, 5, 1);
        check("disable_idle_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge ACLK);
            if (adc_req === 1'b1) seen++;
        end
        check("disable_no_restart", seen, 0);

        // Overrun: long PI computation spans several ticks.
        cfg_period = 16'd3;
        cfg_enable = 1'b1;
        do_iter(16'h0010, 16'h0008, 16'h0042, 0, 8, 0, 0);
        cfg_enable = 1'b0;
        @(negedge ACLK);
        check("overrun_set", overrun, 1);
        check("overrun_busy", busy, 0);
        status_clr = 1'b1;
        @(negedge ACLK);
        status_clr = 1'b0;
        check("overrun_cleared", overrun, 0);
        @(negedge ACLK);
        check("overrun_stays_clear", overrun, 0);

        // Timeout: ADC never answers.
        cfg_period = 16'd0;
        cfg_enable = 1'b1;
        n = 0;
        while (adc_req !== 1'b1 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("to_adc_req_seen", adc_req, 1);
        n = 0;
        while (fault !== 1'b1 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        check("to_cycles", n, 64);
        check("to_adc_req_low", adc_req, 0);
        check("to_pi_start_low", pi_start, 0);
        check("to_dac_valid_low", dac_valid, 0);
        check("to_busy", busy, 1);
        check("to_overrun", overrun, 1);
        repeat (5) @(negedge ACLK);
        check("to_fault_held", fault, 1);
        cfg_enable = 1'b0;
        @(negedge ACLK);
        check("to_fault_exit", fault, 0);
        check("to_idle_busy", busy, 0);

        // Asynchronous reset while in COMPUTE.
        cfg_period   = 16'd5;
        cfg_setpoint = 16'h0000;
        cfg_enable   = 1'b1;
        n = 0;
        while (adc_req !== 1'b1 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        adc_valid = 1'b1;
        adc_data  = 16'h1234;
        @(negedge ACLK);
        adc_valid = 1'b0;
        check("arst_pre_pi_start", pi_start, 1);
        check("arst_pre_pi_error", pi_error, model_err(16'h0000, 16'h1234));
        #2 ARESETN = 1'b0;
        #1;
        check("arst_pi_start", pi_start, 0);
        check("arst_pi_error", pi_error, 0);
        check("arst_adc_req", adc_req, 0);
        check("arst_dac_valid", dac_valid, 0);
        check("arst_dac_data", dac_data, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_fault", fault, 0);
        check("arst_iter_cnt", iter_cnt, 0);
        @(negedge ACLK);
        ARESETN  = 1'b1;
        exp_iter = 0;
        do_iter(16'h0050, 16'h0020, 16'h0777, 0, 1, 0, 0);

`ifdef PI_SEQ_OUT_CLAMP_EN
        // Output clamp, including an inverted window.
        cfg_period  = 16'd9;
        cfg_out_min = 16'hFF9C;
        cfg_out_max = 16'd100;
        do_iter(16'h0010, 16'h0000, 16'd500, 0, 0, 0, 0);
        check("clamp_max_value", last_dac, 16'd100);
        check("clamp_max_hit", last_hit, 1);
        @(negedge ACLK);
        check("clamp_hit_pulse", clamp_hit, 0);
        do_iter(16'h0010, 16'h0000, 16'd50, 0, 0, 0, 0);
        check("clamp_inside_value", last_dac, 16'd50);
        check("clamp_inside_hit", last_hit, 0);
        cfg_out_min = 16'd50;
        cfg_out_max = 16'hFFCE;
        do_iter(16'h0010, 16'h0000, 16'd7, 0, 0, 0, 0);
        check("clamp_inverted_value", last_dac, 16'd50);
        cfg_out_min = 16'h8000;
        cfg_out_max = 16'h7FFF;
`endif

        cfg_enable = 1'b0;
        repeat (3) @(negedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
